// File: rtl/dict_finder.sv
// dict_finder: dictionary search engine for the ForthSuper outer interpreter.
// Skips leading blanks in the TIB, measures the next token, then walks the
// linked dictionary from a context LFA looking for a name of equal length and
// equal characters. Memory is a byte-wide read port with one cycle of latency.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         1-cycle request, taken only while bsy=0
//   ctx           LFA of the newest dictionary word (latched on start)
//   tib_a         first TIB byte address (latched on start)
//   mem_a         memory read address; data returns on mem_q next cycle
//   mem_q         memory read data
//   bsy           search in progress
//   done          1-cycle pulse, results valid
//   hit, imm      token found / immediate flag of the found word
//   pfa           address following the found name
//   tlen          token length (all-ones when the token is too long)
//   tib_nxt       TIB resume address
module dict_finder #(
    parameter int unsigned DSZ   = 8,
    parameter int unsigned ASZ   = 17,
    parameter int unsigned LSZ   = 2,
    parameter int unsigned NSZ   = 5,
    parameter bit          ICASE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [ASZ-1:0] ctx,
    input  logic [ASZ-1:0] tib_a,
    output logic [ASZ-1:0] mem_a,
    input  logic [DSZ-1:0] mem_q,
    output logic           bsy,
    output logic           done,
    output logic           hit,
    output logic           imm,
    output logic [ASZ-1:0] pfa,
    output logic [NSZ-1:0] tlen,
    output logic [ASZ-1:0] tib_nxt
);

    localparam int unsigned   LW   = 8 * LSZ;
    localparam int unsigned   CW   = NSZ + 1;
    localparam logic [ASZ-1:0] HOFS = ASZ'(LSZ + 1);
    localparam logic [1:0]    BEND = 2'(LSZ);
    localparam logic [DSZ-1:0] SP  = DSZ'(8'h20);
    localparam logic [DSZ-1:0] NUL = DSZ'(8'h00);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_TLEN,
        S_LNK,
        S_LEN,
        S_CMP
    } state_t;

    state_t         state;
    logic [ASZ-1:0] ctx_r;     // latched context LFA
    logic [ASZ-1:0] tst;       // token start address
    logic [ASZ-1:0] cur;       // LFA of the entry being examined
    logic [LW-1:0]  lnk;       // link field of the current entry
    logic [CW-1:0]  cnt;       // token length counter, saturates at 2**NSZ
    logic [NSZ-1:0] ci;        // character index inside CMP
    logic           ph;        // CMP phase: 0 = dict byte arriving, 1 = TIB byte arriving
    logic [DSZ-1:0] dch;       // folded dictionary character awaiting its TIB partner
    logic           immb;      // immediate bit of the entry under comparison
    logic           pr;        // mem_q holds a TIB byte (false on the first SKIP cycle)
    logic [1:0]     bidx;      // cycle index inside LNK

    logic [ASZ-1:0] prv;       // address of the byte on mem_q during sequential TIB scans
    logic [ASZ-1:0] nma;       // address of the first name byte of the current entry

    assign prv = mem_a - ASZ'(1);
    assign nma = cur + HOFS;

    // ASCII lower-case folding, active only when ICASE is set
    function automatic logic [DSZ-1:0] fold(input logic [DSZ-1:0] c);
        if (ICASE && (c >= DSZ'(8'h61)) && (c <= DSZ'(8'h7A)))
            return c - DSZ'(8'h20);
        return c;
    endfunction

    // Search FSM; each state drives mem_a and consumes the byte requested one cycle earlier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mem_a   <= '0;
            bsy     <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
            imm     <= 1'b0;
            pfa     <= '0;
            tlen    <= '0;
            tib_nxt <= '0;
            ctx_r   <= '0;
            tst     <= '0;
            cur     <= '0;
            lnk     <= '0;
            cnt     <= '0;
            ci      <= '0;
            ph      <= 1'b0;
            dch     <= '0;
            immb    <= 1'b0;
            pr      <= 1'b0;
            bidx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !bsy) begin
                        ctx_r <= ctx;
                        mem_a <= tib_a;
                        bsy   <= 1'b1;
                        hit   <= 1'b0;
                        imm   <= 1'b0;
                        pr    <= 1'b0;
                        state <= S_SKIP;
                    end
                end

                // Sequential TIB reads; the first cycle has no TIB byte yet
                S_SKIP: begin
                    mem_a <= mem_a + ASZ'(1);
                    pr    <= 1'b1;
                    if (pr) begin
                        if (mem_q == NUL) begin
                            tlen    <= '0;
                            tib_nxt <= prv;
                            bsy     <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else if (mem_q != SP) begin
                            tst   <= prv;
                            cnt   <= CW'(1);
                            state <= S_TLEN;
                        end
                    end
                end

                // Count token bytes up to the delimiter
                S_TLEN: begin
                    mem_a <= mem_a + ASZ'(1);
                    if ((mem_q == SP) || (mem_q == NUL)) begin
                        tib_nxt <= (mem_q == SP) ? mem_a : prv;
                        if (cnt[NSZ]) begin
                            tlen  <= '1;
                            bsy   <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            tlen  <= cnt[NSZ-1:0];
                            cur   <= ctx_r;
                            mem_a <= ctx_r;
                            bidx  <= '0;
                            state <= S_LNK;
                        end
                    end else if (!cnt[NSZ]) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Gather the little-endian link, then request the length byte
                S_LNK: begin
                    if ((bidx == 2'd0) && (cur == '0)) begin
                        bsy   <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        if (bidx != 2'd0)
                            lnk <= (lnk >> 8) | (LW'(mem_q[7:0]) << (LW - 8));
                        if (bidx == BEND) begin
                            mem_a <= nma;
                            state <= S_LEN;
                        end else begin
                            mem_a <= mem_a + ASZ'(1);
                            bidx  <= bidx + 2'd1;
                        end
                    end
                end

                // Length/smudge filter before any character is compared
                S_LEN: begin
                    if (!mem_q[6] && (mem_q[NSZ-1:0] == tlen)) begin
                        immb  <= mem_q[7];
                        ci    <= '0;
                        ph    <= 1'b0;
                        mem_a <= tst;
                        state <= S_CMP;
                    end else begin
                        cur   <= ASZ'(lnk);
                        mem_a <= ASZ'(lnk);
                        bidx  <= '0;
                        state <= S_LNK;
                    end
                end

                // Interleaved dictionary/TIB reads, one character every two cycles
                S_CMP: begin
                    if (!ph) begin
                        dch   <= fold(mem_q);
                        mem_a <= nma + ASZ'(ci) + ASZ'(1);
                        ph    <= 1'b1;
                    end else if (fold(mem_q) != dch) begin
                        cur   <= ASZ'(lnk);
                        mem_a <= ASZ'(lnk);
                        bidx  <= '0;
                        state <= S_LNK;
                    end else if ((ci + NSZ'(1)) == tlen) begin
                        hit   <= 1'b1;
                        imm   <= immb;
                        pfa   <= nma + ASZ'(tlen);
                        bsy   <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        ci    <= ci + NSZ'(1);
                        ph    <= 1'b0;
                        mem_a <= tst + ASZ'(ci) + ASZ'(1);
                    end
                end

                default: begin
                    bsy   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_finder.sv
// Bench for dict_finder: directed dictionary scenarios plus randomized
// dictionaries/TIBs checked against a behavioural search model.
module tb_dict_finder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1;
    logic [16:0] ctx_i, tib_i;
    logic [16:0] mem_a0, mem_a1, pfa0, pfa1, nxt0, nxt1;
    logic [7:0]  mem_q0, mem_q1;
    logic        bsy0, bsy1, done0, done1, hit0, hit1, imm0, imm1;
    logic [4:0]  tlen0, tlen1;

    logic [7:0]  mem [0:131071];

    dict_finder #(.DSZ(8), .ASZ(17), .LSZ(2), .NSZ(5), .ICASE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ctx(ctx_i), .tib_a(tib_i),
        .mem_a(mem_a0), .mem_q(mem_q0), .bsy(bsy0), .done(done0), .hit(hit0),
        .imm(imm0), .pfa(pfa0), .tlen(tlen0), .tib_nxt(nxt0));

    dict_finder #(.DSZ(8), .ASZ(17), .LSZ(2), .NSZ(5), .ICASE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ctx(ctx_i), .tib_a(tib_i),
        .mem_a(mem_a1), .mem_q(mem_q1), .bsy(bsy1), .done(done1), .hit(hit1),
        .imm(imm1), .pfa(pfa1), .tlen(tlen1), .tib_nxt(nxt1));

    always @(posedge clk) begin
        mem_q0 <= mem[mem_a0];
        mem_q1 <= mem[mem_a1];
    end

    // view of the instance selected by sel
    bit          sel;
    logic [16:0] s_mem_a, s_pfa, s_nxt;
    logic        s_bsy, s_done, s_hit, s_imm;
    logic [4:0]  s_tlen;
    assign s_mem_a = sel ? mem_a1 : mem_a0;
    assign s_pfa   = sel ? pfa1   : pfa0;
    assign s_nxt   = sel ? nxt1   : nxt0;
    assign s_bsy   = sel ? bsy1   : bsy0;
    assign s_done  = sel ? done1  : done0;
    assign s_hit   = sel ? hit1   : hit0;
    assign s_imm   = sel ? imm1   : imm0;
    assign s_tlen  = sel ? tlen1  : tlen0;

    int n_cmp = 0;
    int n_bad = 0;

    // results of the last run
    logic        r_hit, r_imm, r_to, r_fb;
    logic [16:0] r_pfa, r_nxt, r_lo;
    logic [4:0]  r_tlen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 16'h2000; i++) mem[i] = 8'h00;
    endtask

    task automatic put_str(input logic [16:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem[a + 17'(i)] = s[i];
        mem[a + 17'(s.len())] = 8'h00;
    endtask

    task automatic base_dict();
        mem[17'h0100] = 8'h00; mem[17'h0101] = 8'h00; mem[17'h0102] = 8'h03;
        mem[17'h0103] = "D";   mem[17'h0104] = "U";   mem[17'h0105] = "P";
        mem[17'h0106] = 8'h00; mem[17'h0107] = 8'h01; mem[17'h0108] = 8'h04;
        mem[17'h0109] = "D";   mem[17'h010A] = "R";   mem[17'h010B] = "O";
        mem[17'h010C] = "P";
    endtask

    // one search on the selected instance, bounded wait for done
    task automatic run(input bit which, input logic [16:0] c, input logic [16:0] t, input string tag);
        sel = which;
        @(negedge clk);
        ctx_i = c; tib_i = t;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        r_lo = 17'h1FFFF; r_fb = 1'b0; r_to = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (s_mem_a < r_lo) r_lo = s_mem_a;
            if (s_mem_a >= 17'h010A && s_mem_a <= 17'h010C) r_fb = 1'b1;
            if (s_done) begin r_to = 1'b0; break; end
            @(negedge clk);
        end
        chk({tag, ".timeout"}, 32'(r_to), 32'd0);
        r_hit = s_hit; r_imm = s_imm; r_pfa = s_pfa; r_nxt = s_nxt; r_tlen = s_tlen;
        if (!r_to) begin
            chk({tag, ".bsy_at_done"}, 32'(s_bsy), 32'd0);
            @(negedge clk);
            chk({tag, ".done_width"}, 32'(s_done), 32'd0);
        end
    endtask

    function automatic logic [7:0] mfold(input logic [7:0] c, input bit ic);
        if (ic && c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        return c;
    endfunction

    // behavioural search straight from the dictionary rules
    function automatic void model(input logic [16:0] c, input logic [16:0] t, input bit ic,
                                  output bit h, output bit im, output logic [16:0] p,
                                  output logic [4:0] tl, output logic [16:0] nx);
        logic [16:0] a, s, cur;
        logic [7:0]  lb;
        int          n;
        bit          ok;
        h = 0; im = 0; p = '0;
        a = t;
        while (mem[a] == 8'h20) a++;
        if (mem[a] == 8'h00) begin tl = 0; nx = a; return; end
        s = a;
        while (mem[a] != 8'h00 && mem[a] != 8'h20) a++;
        n  = int'(a - s);
        nx = (mem[a] == 8'h20) ? a + 17'd1 : a;
        if (n > 31) begin tl = 5'h1F; return; end
        tl  = 5'(n);
        cur = c;
        for (int guard = 0; guard < 64 && cur != 0; guard++) begin
            lb = mem[cur + 17'd2];
            if (!lb[6] && int'(lb[4:0]) == n) begin
                ok = 1;
                for (int i = 0; i < n; i++)
                    if (mfold(mem[cur + 17'd3 + 17'(i)], ic) != mfold(mem[s + 17'(i)], ic)) ok = 0;
                if (ok) begin h = 1; im = lb[7]; p = cur + 17'd3 + 17'(n); return; end
            end
            cur = {1'b0, mem[cur + 17'd1], mem[cur]};
        end
    endfunction

    logic [7:0]  alph [4];
    logic [7:0]  nm [6][4];
    int          nl [6];
    logic [16:0] ea, prev, tp, lastc;
    logic [7:0]  lb, ch;
    bit          e_h, e_im;
    logic [16:0] e_p, e_nx;
    logic [4:0]  e_tl;
    int          ndone, k, tl_r;

    initial begin
        alph[0] = 8'h41; alph[1] = 8'h42; alph[2] = 8'h61; alph[3] = 8'h62;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ctx_i = '0; tib_i = '0; sel = 0;
        clr();
        #23;
        chk("rst.bsy",  32'(bsy0),   32'd0);
        chk("rst.done", 32'(done0),  32'd0);
        chk("rst.hit",  32'(hit0),   32'd0);
        chk("rst.imm",  32'(imm0),   32'd0);
        chk("rst.pfa",  32'(pfa0),   32'd0);
        chk("rst.tlen", 32'(tlen0),  32'd0);
        chk("rst.nxt",  32'(nxt0),   32'd0);
        chk("rst.mema", 32'(mem_a0), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // basic hit, DROP filtered by length
        base_dict(); put_str(17'h1000, "  DUP 5");
        run(0, 17'h0106, 17'h1000, "dup");
        chk("dup.hit",  32'(r_hit),  32'd1);
        chk("dup.pfa",  32'(r_pfa),  32'h0106);
        chk("dup.tlen", 32'(r_tlen), 32'd3);
        chk("dup.nxt",  32'(r_nxt),  32'h1006);
        chk("dup.imm",  32'(r_imm),  32'd0);
        chk("dup.no_drop_cmp", 32'(r_fb), 32'd0);

        // miss at the end of the chain
        put_str(17'h1000, "DUX");
        run(0, 17'h0106, 17'h1000, "dux");
        chk("dux.hit",  32'(r_hit),  32'd0);
        chk("dux.tlen", 32'(r_tlen), 32'd3);
        chk("dux.nxt",  32'(r_nxt),  32'h1003);

        // blank line: no dictionary reads
        put_str(17'h1000, "   ");
        run(0, 17'h0106, 17'h1000, "blank");
        chk("blank.hit",  32'(r_hit),  32'd0);
        chk("blank.tlen", 32'(r_tlen), 32'd0);
        chk("blank.nxt",  32'(r_nxt),  32'h1003);
        chk("blank.lo",   32'(r_lo >= 17'h1000), 32'd1);

        // smudge hides, immediate reported
        mem[17'h0108] = 8'hC4; put_str(17'h1000, "DROP");
        run(0, 17'h0106, 17'h1000, "smudge");
        chk("smudge.hit",  32'(r_hit),  32'd0);
        chk("smudge.tlen", 32'(r_tlen), 32'd4);
        chk("smudge.nxt",  32'(r_nxt),  32'h1004);
        mem[17'h0108] = 8'h84;
        run(0, 17'h0106, 17'h1000, "immed");
        chk("immed.hit", 32'(r_hit), 32'd1);
        chk("immed.imm", 32'(r_imm), 32'd1);
        chk("immed.pfa", 32'(r_pfa), 32'h010D);
        mem[17'h0108] = 8'h04;

        // case folding
        put_str(17'h1000, "dup ");
        run(1, 17'h0106, 17'h1000, "icase1");
        chk("icase1.hit", 32'(r_hit), 32'd1);
        chk("icase1.pfa", 32'(r_pfa), 32'h0106);
        run(0, 17'h0106, 17'h1000, "icase0");
        chk("icase0.hit", 32'(r_hit), 32'd0);
        chk("icase0.nxt", 32'(r_nxt), 32'h1004);

        // over-long token saturates tlen
        put_str(17'h1000, "AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA");
        run(0, 17'h0106, 17'h1000, "long");
        chk("long.hit",  32'(r_hit),  32'd0);
        chk("long.tlen", 32'(r_tlen), 32'h1F);
        chk("long.nxt",  32'(r_nxt),  32'h1021);

        // reset during CMP aborts with no done
        put_str(17'h1000, "DUP");
        sel = 0;
        @(negedge clk); ctx_i = 17'h0106; tib_i = 17'h1000; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        r_to = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if (mem_a0 == 17'h0103) begin r_to = 1'b0; break; end
            @(negedge clk);
        end
        chk("abort.reach_len", 32'(r_to), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.bsy",  32'(bsy0),  32'd0);
        chk("abort.done", 32'(done0), 32'd0);
        @(negedge clk);
        chk("abort.done_hold", 32'(done0), 32'd0);
        rst_n = 1'b1;
        run(0, 17'h0106, 17'h1000, "after_abort");
        chk("after_abort.hit", 32'(r_hit), 32'd1);
        chk("after_abort.pfa", 32'(r_pfa), 32'h0106);

        // start while busy is ignored
        @(negedge clk); ctx_i = 17'h0106; tib_i = 17'h1000; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk); @(negedge clk);
        ctx_i = 17'h0000; tib_i = 17'h1004; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        ndone = 0;
        for (int n = 0; n < 300; n++) begin
            if (done0) ndone++;
            @(negedge clk);
        end
        chk("busy.ndone", 32'(ndone), 32'd1);
        chk("busy.hit",   32'(hit0),  32'd1);
        chk("busy.pfa",   32'(pfa0),  32'h0106);

        // randomized dictionaries and TIBs
        for (int tr = 0; tr < 24; tr++) begin
            clr();
            prev = '0;
            for (int e = 0; e < 6; e++) begin
                ea = 17'h0200 + 17'(e) * 17'h40 + 17'($urandom_range(0, 7));
                mem[ea] = prev[7:0]; mem[ea + 17'd1] = prev[15:8];
                nl[e] = $urandom_range(1, 4);
                lb = 8'(nl[e]);
                lb[5] = 1'($urandom_range(0, 1));
                lb[6] = ($urandom_range(0, 4) == 0);
                lb[7] = ($urandom_range(0, 2) == 0);
                mem[ea + 17'd2] = lb;
                for (int i = 0; i < nl[e]; i++) begin
                    nm[e][i] = alph[$urandom_range(0, 3)];
                    mem[ea + 17'd3 + 17'(i)] = nm[e][i];
                end
                prev = ea;
            end
            lastc = prev;
            tp = 17'h1100;
            for (int i = $urandom_range(0, 3); i > 0; i--) begin mem[tp] = 8'h20; tp++; end
            if ($urandom_range(0, 7) != 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    k = $urandom_range(0, 5);
                    for (int i = 0; i < nl[k]; i++) begin
                        ch = nm[k][i];
                        if ($urandom_range(0, 1) == 1) ch = ch ^ 8'h20;
                        mem[tp] = ch; tp++;
                    end
                end else begin
                    tl_r = $urandom_range(1, 5);
                    for (int i = 0; i < tl_r; i++) begin mem[tp] = alph[$urandom_range(0, 3)]; tp++; end
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                mem[tp] = 8'h20; mem[tp + 17'd1] = "X"; tp = tp + 17'd2;
            end
            mem[tp] = 8'h00;
            for (int w = 0; w < 2; w++) begin
                model(lastc, 17'h1100, bit'(w), e_h, e_im, e_p, e_tl, e_nx);
                run(bit'(w), lastc, 17'h1100, $sformatf("rnd%0d.%0d", tr, w));
                chk($sformatf("rnd%0d.%0d.hit", tr, w),  32'(r_hit),  32'(e_h));
                chk($sformatf("rnd%0d.%0d.imm", tr, w),  32'(r_imm),  32'(e_im));
                chk($sformatf("rnd%0d.%0d.tlen", tr, w), 32'(r_tlen), 32'(e_tl));
                chk($sformatf("rnd%0d.%0d.nxt", tr, w),  32'(r_nxt),  32'(e_nx));
                if (e_h) chk($sformatf("rnd%0d.%0d.pfa", tr, w), 32'(r_pfa), 32'(e_p));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
